mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the single external memory port between the instruction-cache refill engine and the data-cache refill/writeback engine. Each grant runs a fixed-length burst of BURST_LEN beats with a sequencing FSM and beat counter. The block raises a stall request toward the pipeline stall controller while any cache transaction is outstanding. Grants are round-robin, with the data side preferred after reset.

## Interface
- ADDR_W, 32, address width in bits.
- DATA_W, 32, beat width in bits. Byte stride per beat is DATA_W/8.
- BURST_LEN, 4, beats per transaction. Must be a power of two and at least 1.
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- i_req  in  1  icache refill request. Held high until i_done.
- i_addr  in  ADDR_W  icache line base address. Stable while i_req is high.
- i_rdata  out  DATA_W  read beat data.
- i_rvalid  out  1  i_rdata valid this cycle.
- i_done  out  1  one-cycle pulse: icache transaction complete.
- d_req  in  1  dcache request. Held high until d_done.
- d_we  in  1  1 = writeback, 0 = refill. Stable while d_req is high.
- d_addr  in  ADDR_W  dcache line base address.
- d_wdata  in  DATA_W  current writeback beat.
- d_wready  out  1  d_wdata accepted this cycle. Requester advances to the next beat.
- d_rdata  out  DATA_W  refill beat data.
- d_rvalid  out  1  d_rdata valid this cycle.
- d_done  out  1  one-cycle pulse: dcache transaction complete.
- m_req  out  1  memory beat request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  beat address.
- m_wdata  out  DATA_W  write data.
- m_ready  in  1  beat completes when m_req && m_ready. For reads, m_rdata is valid in that cycle.
- m_rdata  in  DATA_W  read data.
- stall_req  out  1  to the pipeline stall controller.

## Operation
- FSM states: IDLE, GNT_I, GNT_D, DONE. Registers:
  - base address
  - owner (I/D)
  - write flag
  - beat counter, width log2(BURST_LEN) with a minimum of 1
  - last_owner
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the side that is not last_owner.
  - On a grant, latch the address and d_we (d_we forced to 0 for I), clear the beat counter, and update last_owner.
- last_owner resets to I, so D wins the first tie.
- GNT_x:
  - Outputs: m_req=1, m_we=write flag, m_addr = base + count*(DATA_W/8), modulo 2^ADDR_W.
  - Each cycle with m_ready=1 is a beat; the counter increments on each beat.
  - On the beat with count == BURST_LEN-1, go to DONE.
- Read beats route m_rdata to the owner's rdata port. rvalid = m_ready in GNT_x for the owner only.
- Write beats:
  - m_wdata = d_wdata (combinational).
  - d_wready = m_ready in GNT_D when the write flag is set.
- DONE:
  - One cycle. The owner's done output is 1; m_req=0.
  - Requests are not sampled in DONE.
  - Next state is IDLE.
- Requester rule: the req of the completed side must be low in the cycle after its done pulse. A req still high in IDLE is treated as a new transaction.
- A req raised while the other side holds the port waits. It wins the next IDLE arbitration if the finishing side has dropped its req, or by round-robin otherwise.
- stall_req = i_req | d_req | (state != IDLE). This is combinational.
- All other outputs are decoded from registered state. rvalid, rdata and wready pass m_ready/m_rdata through combinationally.
- Outputs are 0 whenever not in the corresponding grant/done state. Unused rdata outputs are 0.

## Timing
- Reset (synchronous): state=IDLE, counter=0, last_owner=I.
- Reset values: m_req, m_we, i_done, d_done, i_rvalid, d_rvalid, d_wready are all 0; m_addr=0, m_wdata=0.
- stall_req with rst high equals i_req|d_req.
- Latency: req seen high in IDLE at cycle N → m_req=1 at N+1.
  - With m_ready tied to 1, beats occur at N+1..N+BURST_LEN.
  - done pulses at N+BURST_LEN+1.
  - IDLE at N+BURST_LEN+2.
  - The earliest next grant's m_req is at N+BURST_LEN+3.
- Wait states: m_ready=0 holds m_addr, the counter and m_wdata stable, and extends the burst one cycle per wait.
- Reset asserted mid-burst: m_req=0 at the next edge. The partial transaction is discarded with no done pulse. Requesters are reset by the same rst.
- Address wrap: base + offset wraps at 2^ADDR_W with no error.

## Test plan
- Icache refill, BURST_LEN=4, i_addr=0x100, m_ready=1, req at cycle 1 → m_addr 0x100/0x104/0x108/0x10C at cycles 2–5, i_rvalid in the same cycles, i_done at cycle 6, stall_req high cycles 1–6.
- i_req and d_req rise together after reset → D granted first. I is granted after d_done, with its first m_req 3 cycles after the last D beat.
- Both sides repeatedly re-request → grants alternate D,I,D,I, with no side granted twice while the other waits.
- Dcache writeback d_addr=0x2000 with m_ready pattern 1,0,0,1,1,1 → 4 beats over 6 cycles, m_addr held at 0x2004 during the waits, d_wready=1 on exactly 4 cycles, d_done one cycle after the 4th beat.
- rst asserted in the 2nd beat of an icache refill → next cycle m_req=0, i_done never pulses, state is IDLE. A fresh request afterwards restarts at the base address.
- d_addr=0xFFFFFFF8 refill → m_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory port between the icache refill
// and dcache refill/writeback engines, one fixed-length burst per grant.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_req
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic              owner_d_q;   // 1 = dcache owns the current/finishing burst
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_d_q;    // 1 = dcache was granted last

    // Dcache wins when alone or when the icache had the previous grant.
    logic pick_d, pick_i;
    assign pick_d = d_req && (!i_req || !last_d_q);
    assign pick_i = i_req && !pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q   <= GNT_D;
                        base_q    <= d_addr;
                        we_q      <= d_we;
                        owner_d_q <= 1'b1;
                        last_d_q  <= 1'b1;
                        cnt_q     <= '0;
                    end else if (pick_i) begin
                        state_q   <= GNT_I;
                        base_q    <= i_addr;
                        we_q      <= 1'b0;
                        owner_d_q <= 1'b0;
                        last_d_q  <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (m_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic gnt, gnt_i, gnt_d;
    assign gnt_i = (state_q == GNT_I);
    assign gnt_d = (state_q == GNT_D);
    assign gnt   = gnt_i | gnt_d;

    assign m_req   = gnt;
    assign m_we    = gnt & we_q;
    assign m_addr  = gnt ? (base_q + ADDR_W'(cnt_q) * STRIDE) : '0;
    assign m_wdata = (gnt_d & we_q) ? d_wdata : '0;

    assign i_rvalid = gnt_i & m_ready;
    assign i_rdata  = gnt_i ? m_rdata : '0;
    assign d_rvalid = gnt_d & ~we_q & m_ready;
    assign d_rdata  = (gnt_d & ~we_q) ? m_rdata : '0;
    assign d_wready = gnt_d & we_q & m_ready;

    assign i_done = (state_q == DONE) & ~owner_d_q;
    assign d_done = (state_q == DONE) & owner_d_q;

    assign stall_req = i_req | d_req | (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected beats and done pulses are queued
// as requests are driven and retired by a negedge monitor.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam logic [DW-1:0] WBASE = 32'hD000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_rvalid, i_done;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_wready, d_rvalid, d_done;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we, m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          stall_req;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction
    assign m_rdata = mem_f(m_addr);

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic          own_d;
        logic [DW-1:0] wdata;
    } beat_t;

    beat_t sb[$];
    logic  dq[$];
    logic  rq[$];
    int    gnt_cyc[$];
    int    cyc = 0;
    int    n_cmp = 0, n_err = 0;
    int    last_beat_cyc = -10;
    int    wr_cnt = 0;
    int    wbeat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_beat(input logic own_d, input logic we, input logic [AW-1:0] a,
                                      input int k);
        beat_t b;
        b.addr  = a;
        b.we    = we;
        b.own_d = own_d;
        b.wdata = we ? (WBASE + 32'(k)) : '0;
        sb.push_back(b);
    endfunction

    function automatic void push_burst(input logic own_d, input logic we, input logic [AW-1:0] base,
                                       input int nb, input logic with_done);
        for (int k = 0; k < nb; k++) push_beat(own_d, we, base + AW'(k * 4), k);
        if (with_done) dq.push_back(own_d);
    endfunction

    // Monitor: retire beats and done pulses against the scoreboard.
    initial begin : mon
        beat_t e;
        logic  own;
        logic  m_req_prev;
        m_req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (m_req === 1'b1 && m_req_prev !== 1'b1) gnt_cyc.push_back(cyc);
            m_req_prev = m_req;
            if (m_req === 1'b1 && m_ready === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got beat at addr %h, required none", m_addr);
                end else begin
                    e = sb.pop_front();
                    if (m_addr !== e.addr) begin
                        n_err++; $display("FAIL beat_addr: got %h required %h", m_addr, e.addr);
                    end
                    n_cmp++;
                    if (m_we !== e.we) begin
                        n_err++; $display("FAIL beat_we: got %b required %b", m_we, e.we);
                    end
                    n_cmp++;
                    if (e.own_d) begin
                        if (d_rvalid !== !e.we || i_rvalid !== 1'b0 || d_wready !== e.we ||
                            d_rdata !== (e.we ? '0 : mem_f(e.addr)) || i_rdata !== '0) begin
                            n_err++;
                            $display("FAIL beat_d_route: got rv_d=%b rv_i=%b wr=%b rd=%h required rv_d=%b rv_i=0 wr=%b rd=%h",
                                     d_rvalid, i_rvalid, d_wready, d_rdata, !e.we, e.we,
                                     e.we ? '0 : mem_f(e.addr));
                        end
                        if (e.we) begin
                            n_cmp++;
                            if (m_wdata !== e.wdata) begin
                                n_err++; $display("FAIL beat_wdata: got %h required %h", m_wdata, e.wdata);
                            end
                        end
                    end else begin
                        if (i_rvalid !== 1'b1 || i_rdata !== mem_f(e.addr) || d_rvalid !== 1'b0 ||
                            d_wready !== 1'b0 || d_rdata !== '0) begin
                            n_err++;
                            $display("FAIL beat_i_route: got rv_i=%b rd=%h rv_d=%b wr=%b required rv_i=1 rd=%h rv_d=0 wr=0",
                                     i_rvalid, i_rdata, d_rvalid, d_wready, mem_f(e.addr));
                        end
                    end
                end
                last_beat_cyc = cyc;
            end else if (m_req === 1'b1 && sb.size() > 0) begin
                e = sb[0];
                n_cmp++;
                if (m_addr !== e.addr || (e.we && m_wdata !== e.wdata) || d_wready !== 1'b0 ||
                    i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                    n_err++;
                    $display("FAIL wait_hold: got addr=%h wdata=%h wr=%b required addr=%h wdata=%h wr=0",
                             m_addr, m_wdata, d_wready, e.addr, e.wdata);
                end
            end
            if (i_done === 1'b1 || d_done === 1'b1) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_err++; $display("FAIL done_unexpected: got i_done=%b d_done=%b required none", i_done, d_done);
                end else begin
                    own = dq.pop_front();
                    if (d_done !== own || i_done !== !own) begin
                        n_err++; $display("FAIL done_owner: got i=%b d=%b required d=%b", i_done, d_done, own);
                    end
                end
                n_cmp++;
                if (cyc != last_beat_cyc + 1) begin
                    n_err++; $display("FAIL done_timing: got cycle %0d required %0d", cyc, last_beat_cyc + 1);
                end
            end
        end
    end

    // Requesters: hold req for the given number of transactions, drop after the last done.
    task automatic run(input int ri, input int rd, input int budget);
        int   rem_i = ri;
        int   rem_d = rd;
        int   c = 0;
        logic si, sd, wr;
        while ((rem_i > 0 || rem_d > 0) && c < budget) begin
            @(negedge clk);
            si = i_done; sd = d_done; wr = d_wready; c++;
            if (wr === 1'b1) wr_cnt++;
            @(posedge clk); #1;
            m_ready = (rq.size() > 0) ? rq.pop_front() : 1'b1;
            if (wr === 1'b1) begin wbeat++; d_wdata = WBASE + 32'(wbeat); end
            if (si === 1'b1) begin rem_i--; if (rem_i == 0) i_req = 1'b0; end
            if (sd === 1'b1) begin
                rem_d--; wbeat = 0; d_wdata = WBASE;
                if (rem_d == 0) begin d_req = 1'b0; d_we = 1'b0; end
            end
        end
        n_cmp++;
        if (rem_i != 0 || rem_d != 0) begin
            n_err++; $display("FAIL run_timeout: got remaining i=%0d d=%0d required 0", rem_i, rem_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = WBASE; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_req, m_we, i_done, d_done, i_rvalid, d_rvalid, d_wready} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b required 0000000",
                              {m_req, m_we, i_done, d_done, i_rvalid, d_rvalid, d_wready});
        end
        n_cmp++;
        if (m_addr !== '0 || m_wdata !== '0) begin
            n_err++; $display("FAIL reset_bus: got addr=%h wdata=%h required 0", m_addr, m_wdata);
        end
        n_cmp++;
        if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall_idle: got %b required 0", stall_req); end
        i_req = 1'b1; #1;
        n_cmp++;
        if (stall_req !== 1'b1) begin n_err++; $display("FAIL reset_stall_req: got %b required 1", stall_req); end
        i_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_icache_refill();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h100; m_ready = 1'b1;
        push_burst(1'b0, 1'b0, 32'h100, BL, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (stall_req !== (k <= 5)) begin
                n_err++; $display("FAIL icache_stall k=%0d: got %b required %b", k, stall_req, k <= 5);
            end
            n_cmp++;
            if (i_rvalid !== (k >= 1 && k <= 4)) begin
                n_err++; $display("FAIL icache_rvalid k=%0d: got %b required %b", k, i_rvalid, k >= 1 && k <= 4);
            end
            n_cmp++;
            if (i_done !== (k == 5)) begin
                n_err++; $display("FAIL icache_done k=%0d: got %b required %b", k, i_done, k == 5);
            end
            @(posedge clk); #1;
            if (k == 5) i_req = 1'b0;
        end
    endtask

    task automatic test_tie();
        gnt_cyc.delete();
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        push_burst(1'b1, 1'b0, 32'h4000, BL, 1'b1);
        push_burst(1'b0, 1'b0, 32'h500, BL, 1'b1);
        run(1, 1, 40);
        n_cmp++;
        if (gnt_cyc.size() != 2) begin
            n_err++; $display("FAIL tie_grants: got %0d grants required 2", gnt_cyc.size());
        end else if (gnt_cyc[1] - gnt_cyc[0] != BL + 2) begin
            n_err++; $display("FAIL tie_gap: got %0d cycles required %0d", gnt_cyc[1] - gnt_cyc[0], BL + 2);
        end
    endtask

    task automatic test_back_to_back();
        gnt_cyc.delete();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h700;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6000;
        for (int t = 0; t < 2; t++) begin
            push_burst(1'b1, 1'b1, 32'h6000, BL, 1'b1);
            push_burst(1'b0, 1'b0, 32'h700, BL, 1'b1);
        end
        run(2, 2, 80);
        n_cmp++;
        if (gnt_cyc.size() != 4) begin
            n_err++; $display("FAIL rr_grants: got %0d grants required 4", gnt_cyc.size());
        end
    endtask

    task automatic test_writeback_waits();
        @(posedge clk); #1;
        wr_cnt = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; m_ready = 1'b1;
        rq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        push_burst(1'b1, 1'b1, 32'h2000, BL, 1'b1);
        run(0, 1, 30);
        n_cmp++;
        if (wr_cnt != 4) begin n_err++; $display("FAIL wb_wready_count: got %0d required 4", wr_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h300; m_ready = 1'b1;
        push_burst(1'b0, 1'b0, 32'h300, 2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (m_req !== 1'b0 || stall_req !== 1'b0 || i_done !== 1'b0) begin
            n_err++; $display("FAIL rst_mid: got m_req=%b stall=%b done=%b required 0 0 0", m_req, stall_req, i_done);
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL rst_mid_beats: got %0d pending required 0", sb.size()); end
        @(posedge clk); #1 rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h300;
        push_burst(1'b0, 1'b0, 32'h300, BL, 1'b1);
        run(1, 0, 30);
    endtask

    task automatic test_addr_wrap();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hFFFF_FFF8;
        push_beat(1'b1, 1'b0, 32'hFFFF_FFF8, 0);
        push_beat(1'b1, 1'b0, 32'hFFFF_FFFC, 1);
        push_beat(1'b1, 1'b0, 32'h0000_0000, 2);
        push_beat(1'b1, 1'b0, 32'h0000_0004, 3);
        dq.push_back(1'b1);
        run(0, 1, 30);
    endtask

    initial begin
        test_reset();
        test_icache_refill();
        test_tie();
        test_back_to_back();
        test_writeback_waits();
        test_reset_mid_burst();
        test_addr_wrap();
        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0 || dq.size() != 0) begin
            n_err++; $display("FAIL drain: got %0d beats %0d dones pending required 0", sb.size(), dq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
